// File: rtl/snake_pkg.sv
// Shared definitions for the snake game sequencer.
// Holds the direction codes, the sequencer state encoding, coordinate and
// segment widths, and the direction-reversal helper.
package snake_pkg;

    localparam int COORD_W = 4;
    localparam int SEG_W   = 8;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        CHECK,
        ISSUE,
        DEAD
    } state_t;

    // Up/down and left/right differ only in bit 0.
    function automatic logic [1:0] dir_reverse(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/snake_lfsr.sv
// 8-bit Fibonacci LFSR (x^8 + x^6 + x^5 + x^4 + 1) used for food placement.
// Ports:
//   i_clk, i_rst_n : clock and asynchronous active-low reset (loads SEED)
//   i_en           : advance one step per cycle when high
//   o_q            : current LFSR state
module snake_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    output logic [7:0] o_q
);

    logic [7:0] r_q;
    logic       w_fb;

    assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= SEED;
        end else if (i_en) begin
            r_q <= {r_q[6:0], w_fb};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: divides slw_clk into move ticks, arbitrates the
// direction buttons (reversals rejected), checks wall/self/food collisions
// and issues one move per tick to the body datapath over move_req/move_ack.
// Owns food position, length, score and game-over status.
//
// Build option: define SNAKE_WRAP_WALLS_EN to make moves wrap at the grid
// edges instead of killing the snake.
//
// Ports:
//   slw_clk, reset          : clock, asynchronous active-low reset
//   start                   : begin/restart a game (IDLE or DEAD only)
//   up/down/left/right      : level direction buttons
//   head_x, head_y          : current head from the datapath
//   self_hit                : datapath says cand overlaps the body (CHECK)
//   move_ack                : datapath accepted the move
//   move_req/move_dir/grow  : move command to the datapath
//   cand_x, cand_y          : candidate next head
//   food_x, food_y          : food position
//   score, length           : foods eaten (saturating), snake length
//   running, game_over      : status
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | waiting for start after reset
// WAIT_TICK | counting move tick, arbitrating buttons
// CHECK     | one cycle: wall/self/food evaluation
// ISSUE     | move_req high until move_ack
// DEAD      | game over, waiting for start
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int         GRID_W    = 16,
    parameter int         GRID_H    = 16,
    parameter int         MOVE_DIV  = 4,
    parameter int         MAX_LEN   = 225,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic               slw_clk,
    input  logic               reset,
    input  logic               start,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    input  logic               self_hit,
    input  logic               move_ack,
    output logic               move_req,
    output logic [1:0]         move_dir,
    output logic               grow,
    output logic [COORD_W-1:0] cand_x,
    output logic [COORD_W-1:0] cand_y,
    output logic [COORD_W-1:0] food_x,
    output logic [COORD_W-1:0] food_y,
    output logic [7:0]         score,
    output logic [7:0]         length,
    output logic               running,
    output logic               game_over
);

    localparam int                  TICK_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(MOVE_DIV - 1);
    localparam logic [COORD_W-1:0]  X_MAX     = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0]  Y_MAX     = COORD_W'(GRID_H - 1);
    localparam logic [7:0]          LEN_MAX   = 8'(MAX_LEN);
    localparam logic [COORD_W-1:0]  FOOD_INIT = COORD_W'(3);
    localparam logic [7:0]          LEN_INIT  = 8'd3;

    // LFSR nibbles can exceed a grid smaller than 16; fold them back once.
    function automatic logic [COORD_W-1:0] fold(input logic [COORD_W-1:0] v, input int grid);
        if (int'(v) >= grid) begin
            return v - COORD_W'(grid);
        end
        return v;
    endfunction

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_dir, r_pend, w_arb, w_rev;
    logic [TICK_W-1:0]    r_tick;
    logic                 w_tick_done, w_wall, w_food_hit, r_grow;
    logic [COORD_W-1:0]   w_inc_x, w_dec_x, w_inc_y, w_dec_y;
    logic [COORD_W-1:0]   w_cand_x, w_cand_y, r_cand_x, r_cand_y;
    logic [COORD_W-1:0]   r_food_x, r_food_y;
    logic [7:0]           r_score, r_len;
    logic [SEG_W-1:0]     w_lfsr;

    snake_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk   (slw_clk),
        .i_rst_n (reset),
        .i_en    (1'b1),
        .o_q     (w_lfsr)
    );

    // Lowest priority assigned first so higher-priority buttons override.
    assign w_rev = dir_reverse(r_dir);
    always_comb begin
        w_arb = r_pend;
        if (right && (DIR_RIGHT != w_rev)) w_arb = DIR_RIGHT;
        if (left  && (DIR_LEFT  != w_rev)) w_arb = DIR_LEFT;
        if (down  && (DIR_DOWN  != w_rev)) w_arb = DIR_DOWN;
        if (up    && (DIR_UP    != w_rev)) w_arb = DIR_UP;
    end

    assign w_tick_done = (r_tick == TICK_LAST);

`ifdef SNAKE_WRAP_WALLS_EN
    assign w_inc_x = (head_x == X_MAX) ? '0 : head_x + COORD_W'(1);
    assign w_dec_x = (head_x == '0)    ? X_MAX : head_x - COORD_W'(1);
    assign w_inc_y = (head_y == Y_MAX) ? '0 : head_y + COORD_W'(1);
    assign w_dec_y = (head_y == '0)    ? Y_MAX : head_y - COORD_W'(1);
    assign w_wall  = 1'b0;
`else
    assign w_inc_x = head_x + COORD_W'(1);
    assign w_dec_x = head_x - COORD_W'(1);
    assign w_inc_y = head_y + COORD_W'(1);
    assign w_dec_y = head_y - COORD_W'(1);

    always_comb begin
        w_wall = 1'b0;
        case (r_dir)
            DIR_UP:    w_wall = (head_y == '0);
            DIR_DOWN:  w_wall = (head_y == Y_MAX);
            DIR_LEFT:  w_wall = (head_x == '0);
            DIR_RIGHT: w_wall = (head_x == X_MAX);
            default:   w_wall = 1'b0;
        endcase
    end
`endif

    // Candidate is captured at tick expiry with the newly committed
    // direction, so it is already stable for the datapath during CHECK.
    always_comb begin
        w_cand_x = head_x;
        w_cand_y = head_y;
        case (w_arb)
            DIR_UP:    w_cand_y = w_dec_y;
            DIR_DOWN:  w_cand_y = w_inc_y;
            DIR_LEFT:  w_cand_x = w_dec_x;
            DIR_RIGHT: w_cand_x = w_inc_x;
            default:   w_cand_x = head_x;
        endcase
    end

    assign w_food_hit = (r_cand_x == r_food_x) && (r_cand_y == r_food_y);

    always_ff @(posedge slw_clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        move_req    = 1'b0;
        running     = 1'b0;
        game_over   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_state_nxt = WAIT_TICK;
            end
            WAIT_TICK: begin
                running = 1'b1;
                if (w_tick_done) w_state_nxt = CHECK;
            end
            CHECK: begin
                running = 1'b1;
                if (w_wall || self_hit) w_state_nxt = DEAD;
                else                    w_state_nxt = ISSUE;
            end
            ISSUE: begin
                running  = 1'b1;
                move_req = 1'b1;
                if (move_ack) w_state_nxt = WAIT_TICK;
            end
            DEAD: begin
                game_over = 1'b1;
                if (start) w_state_nxt = WAIT_TICK;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge slw_clk or negedge reset) begin
        if (!reset) begin
            r_dir    <= DIR_RIGHT;
            r_pend   <= DIR_RIGHT;
            r_tick   <= '0;
            r_grow   <= 1'b0;
            r_cand_x <= '0;
            r_cand_y <= '0;
            r_food_x <= FOOD_INIT;
            r_food_y <= FOOD_INIT;
            r_score  <= '0;
            r_len    <= LEN_INIT;
        end else begin
            case (r_state)
                IDLE, DEAD: begin
                    if (start) begin
                        r_dir    <= DIR_RIGHT;
                        r_pend   <= DIR_RIGHT;
                        r_tick   <= '0;
                        r_grow   <= 1'b0;
                        r_food_x <= FOOD_INIT;
                        r_food_y <= FOOD_INIT;
                        r_score  <= '0;
                        r_len    <= LEN_INIT;
                    end
                end
                WAIT_TICK: begin
                    r_pend <= w_arb;
                    if (w_tick_done) begin
                        r_tick   <= '0;
                        r_dir    <= w_arb;
                        r_cand_x <= w_cand_x;
                        r_cand_y <= w_cand_y;
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end
                CHECK: begin
                    r_grow <= w_food_hit && (r_len < LEN_MAX);
                end
                ISSUE: begin
                    if (move_ack) begin
                        r_grow <= 1'b0;
                        if (r_grow) begin
                            r_len    <= r_len + 8'd1;
                            r_score  <= (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                            r_food_x <= fold(w_lfsr[COORD_W-1:0], GRID_W);
                            r_food_y <= fold(w_lfsr[SEG_W-1:COORD_W], GRID_H);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign move_dir = r_dir;
    assign grow     = r_grow;
    assign cand_x   = r_cand_x;
    assign cand_y   = r_cand_y;
    assign food_x   = r_food_x;
    assign food_y   = r_food_y;
    assign score    = r_score;
    assign length   = r_len;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl. Expected move commands are queued
// by the stimulus thread; a forked monitor pops and compares them whenever
// the DUT raises move_req. A small datapath responder acks moves and
// tracks the head.
module tb_snake_game_ctrl;

    typedef struct packed {
        logic [1:0] dir;
        logic       grow;
        logic [3:0] cx;
        logic [3:0] cy;
        logic [7:0] gap;
    } exp_t;

    logic       slw_clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [3:0] head_x = 4'd1, head_y = 4'd3;
    logic       self_hit = 1'b0;
    logic       move_ack = 1'b0;
    logic       move_req, grow, running, game_over;
    logic [1:0] move_dir;
    logic [3:0] cand_x, cand_y, food_x, food_y;
    logic [7:0] score, length;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         ack_cnt = 0;
    int         ack_hold = 0;
    int         hold_cnt = 0;
    int         load_seq = 0;
    int         load_seen = 0;
    logic [3:0] load_x = 4'd0, load_y = 4'd0;
    logic [7:0] tb_lfsr;
    logic [7:0] lfsr_at_ack = 8'h00;

    int         exp_len, exp_score;
    logic [3:0] exp_fx, exp_fy;
    logic       g;

    snake_game_ctrl dut (
        .slw_clk   (slw_clk),
        .reset     (reset),
        .start     (start),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .head_x    (head_x),
        .head_y    (head_y),
        .self_hit  (self_hit),
        .move_ack  (move_ack),
        .move_req  (move_req),
        .move_dir  (move_dir),
        .grow      (grow),
        .cand_x    (cand_x),
        .cand_y    (cand_y),
        .food_x    (food_x),
        .food_y    (food_y),
        .score     (score),
        .length    (length),
        .running   (running),
        .game_over (game_over)
    );

    always #5 slw_clk = ~slw_clk;

    always @(posedge slw_clk) cyc <= cyc + 1;

    // Reference food LFSR: x^8 + x^6 + x^5 + x^4 + 1, seed A5.
    always @(posedge slw_clk or negedge reset) begin
        if (!reset) tb_lfsr <= 8'hA5;
        else        tb_lfsr <= {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
    end

    // Datapath responder: acks after ack_hold cycles, moves the head on ack.
    always @(negedge slw_clk) begin
        if (!reset) begin
            move_ack = 1'b0;
            hold_cnt = 0;
            head_x   = 4'd1;
            head_y   = 4'd3;
        end else begin
            if (load_seq != load_seen) begin
                load_seen = load_seq;
                head_x    = load_x;
                head_y    = load_y;
            end
            if (move_ack) begin
                move_ack = 1'b0;
                hold_cnt = 0;
                ack_cnt  = ack_cnt + 1;
                case (move_dir)
                    2'b00:   head_y = head_y - 4'd1;
                    2'b01:   head_y = head_y + 4'd1;
                    2'b10:   head_x = head_x - 4'd1;
                    default: head_x = head_x + 4'd1;
                endcase
            end else if (move_req) begin
                if (hold_cnt >= ack_hold) begin
                    move_ack    = 1'b1;
                    lfsr_at_ack = tb_lfsr;
                end else begin
                    hold_cnt = hold_cnt + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] red(input logic [3:0] v, input int gr);
        return (int'(v) >= gr) ? 4'(int'(v) - gr) : v;
    endfunction

    task automatic push_exp(input logic [1:0] d, input logic gw, input logic [3:0] cx,
                            input logic [3:0] cy, input logic [7:0] gap);
        exp_t e;
        e.dir = d; e.grow = gw; e.cx = cx; e.cy = cy; e.gap = gap;
        sb_q.push_back(e);
    endtask

    task automatic mon_loop();
        exp_t cur;
        logic prev = 1'b0;
        logic have = 1'b0;
        int   last_rise = 0;
        forever begin
            @(negedge slw_clk);
            if (!reset) begin
                prev = 1'b0;
                have = 1'b0;
            end else begin
                if (move_req && !prev) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        have = 1'b0;
                        $display("FAIL unexpected_move_req: got dir=%0d cand=(%0d,%0d) expected no move",
                                 move_dir, cand_x, cand_y);
                    end else begin
                        cur  = sb_q.pop_front();
                        have = 1'b1;
                        chk("move_dir", 32'(move_dir), 32'(cur.dir));
                        chk("grow", 32'(grow), 32'(cur.grow));
                        chk("cand_x", 32'(cand_x), 32'(cur.cx));
                        chk("cand_y", 32'(cand_y), 32'(cur.cy));
                        if (cur.gap != 8'd0) chk("req_period", 32'(cyc - last_rise), 32'(cur.gap));
                    end
                    last_rise = cyc;
                end else if (move_req && have) begin
                    chk("hold_dir", 32'(move_dir), 32'(cur.dir));
                    chk("hold_grow", 32'(grow), 32'(cur.grow));
                end
                prev = move_req;
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge slw_clk); #2;
        start = 1'b1;
        @(posedge slw_clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_acks(input int n, input int budget, input string name);
        int k = 0;
        while (ack_cnt < n && k < budget) begin
            @(posedge slw_clk); #2;
            k++;
        end
        chk(name, 32'(ack_cnt >= n), 32'd1);
    endtask

    task automatic wait_dead(input int budget, input string name);
        int k = 0;
        while (!game_over && k < budget) begin
            @(posedge slw_clk); #2;
            k++;
        end
        chk(name, 32'(game_over), 32'd1);
    endtask

    task automatic after_move(input logic gw, input string tag);
        if (gw) begin
            exp_len++;
            exp_score++;
            exp_fx = red(lfsr_at_ack[3:0], 16);
            exp_fy = red(lfsr_at_ack[7:4], 16);
        end
        chk({tag, "_length"}, 32'(length), 32'(exp_len));
        chk({tag, "_score"}, 32'(score), 32'(exp_score));
        chk({tag, "_food_x"}, 32'(food_x), 32'(exp_fx));
        chk({tag, "_food_y"}, 32'(food_y), 32'(exp_fy));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_move_req"}, 32'(move_req), 32'd0);
        chk({tag, "_move_dir"}, 32'(move_dir), 32'd3);
        chk({tag, "_grow"}, 32'(grow), 32'd0);
        chk({tag, "_cand_x"}, 32'(cand_x), 32'd0);
        chk({tag, "_cand_y"}, 32'(cand_y), 32'd0);
        chk({tag, "_food_x"}, 32'(food_x), 32'd3);
        chk({tag, "_food_y"}, 32'(food_y), 32'd3);
        chk({tag, "_score"}, 32'(score), 32'd0);
        chk({tag, "_length"}, 32'(length), 32'd3);
        chk({tag, "_running"}, 32'(running), 32'd0);
        chk({tag, "_game_over"}, 32'(game_over), 32'd0);
    endtask

    initial begin
        int k;
        fork
            mon_loop();
        join_none

        // Reset values while reset is held.
        repeat (3) @(posedge slw_clk);
        #2;
        check_reset_vals("rst");
        reset = 1'b1;
        exp_len = 3; exp_score = 0; exp_fx = 4'd3; exp_fy = 4'd3;

        // Default right: (1,3)->(2,3) plain, then (2,3)->(3,3) eats food.
        push_exp(2'b11, 1'b0, 4'd2, 4'd3, 8'd0);
        push_exp(2'b11, 1'b1, 4'd3, 4'd3, 8'd6);
        pulse_start();
        chk("start_running", 32'(running), 32'd1);
        wait_acks(1, 20, "ack1_timeout");
        after_move(1'b0, "m1");
        wait_acks(2, 20, "ack2_timeout");
        after_move(1'b1, "m2");

        // Left is the reverse of right and must be discarded.
        left = 1'b1;
        g = (exp_fx == 4'd4) && (exp_fy == 4'd3) && (exp_len < 225);
        push_exp(2'b11, g, 4'd4, 4'd3, 8'd6);
        wait_acks(3, 20, "ack3_timeout");
        after_move(g, "m3");

        // Left+up: up wins, snake turns up.
        up = 1'b1;
        g = (exp_fx == 4'd4) && (exp_fy == 4'd2) && (exp_len < 225);
        push_exp(2'b00, g, 4'd4, 4'd2, 8'd6);
        wait_acks(4, 20, "ack4_timeout");
        after_move(g, "m4");
        left = 1'b0;
        up   = 1'b0;

        // Self collision kills; restart reinitialises game state.
        self_hit = 1'b1;
        wait_dead(20, "self_dead");
        chk("self_dead_running", 32'(running), 32'd0);
        chk("self_dead_req", 32'(move_req), 32'd0);
        self_hit = 1'b0;
        exp_len = 3; exp_score = 0; exp_fx = 4'd3; exp_fy = 4'd3;
        push_exp(2'b11, 1'b0, 4'd5, 4'd2, 8'd0);
        pulse_start();
        chk("restart_running", 32'(running), 32'd1);
        chk("restart_game_over", 32'(game_over), 32'd0);
        after_move(1'b0, "restart");
        wait_acks(5, 20, "ack5_timeout");

        // Hold off ack, then reset mid-handshake.
        ack_hold = 10;
        push_exp(2'b11, 1'b0, 4'd6, 4'd2, 8'd0);
        k = 0;
        while (!move_req && k < 20) begin
            @(posedge slw_clk); #2;
            k++;
        end
        chk("m6_req_seen", 32'(move_req), 32'd1);
        repeat (4) @(posedge slw_clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_vals("midrst");
        chk("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
        ack_hold = 0;
        @(posedge slw_clk); #2;
        reset = 1'b1;

        // Head at the right wall moving right.
        load_x = 4'd15;
        load_y = 4'd3;
        load_seq = load_seq + 1;
        repeat (2) @(posedge slw_clk);
`ifdef SNAKE_WRAP_WALLS_EN
        push_exp(2'b11, 1'b0, 4'd0, 4'd3, 8'd0);
        pulse_start();
        wait_acks(6, 20, "wrap_ack_timeout");
        chk("wrap_game_over", 32'(game_over), 32'd0);
        chk("wrap_running", 32'(running), 32'd1);
`else
        pulse_start();
        wait_dead(20, "wall_dead");
        chk("wall_running", 32'(running), 32'd0);
        chk("wall_req", 32'(move_req), 32'd0);
        chk("wall_length", 32'(length), 32'd3);
        repeat (5) @(posedge slw_clk);
        #2;
        chk("wall_still_dead", 32'(game_over), 32'd1);
`endif
        @(posedge slw_clk); #2;
        reset = 1'b0;
        #1;
        chk("end_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
